// File: rtl/kmac_ss_pkg.sv
// rtl/kmac_ss_pkg.sv - shared constants, FSM encoding and byte-swap helper for the digest streamer
package kmac_ss_pkg;

    localparam int StateW         = 1600;
    localparam int DigestMaxWords = StateW / 32;
    localparam int DigestLenW     = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } digest_st_e;

    // Reverse byte order within a 32-bit word when swap is set.
    function automatic logic [31:0] conv_endian32(input logic [31:0] v, input logic swap);
        logic [31:0] r;
        r = swap ? {v[7:0], v[15:8], v[23:16], v[31:24]} : v;
        return r;
    endfunction

endpackage

// File: rtl/caliptra_prim_slicer.sv
// rtl/caliptra_prim_slicer.sv - selects one OutW-wide slice of a wide vector by index
module caliptra_prim_slicer #(
    parameter int InW    = 1600,
    parameter int OutW   = 32,
    parameter int IndexW = 6
) (
    input  logic [IndexW-1:0] sel_i,
    input  logic [InW-1:0]    data_i,
    output logic [OutW-1:0]   data_o
);

    // Pad to the full index range so out-of-range selects read zero.
    localparam int PadW = OutW * (1 << IndexW);

    logic [PadW-1:0] w_pad;

    assign w_pad  = PadW'(data_i);
    assign data_o = w_pad[sel_i * OutW +: OutW];

endmodule

// File: rtl/kmac_ss_digest_streamer.sv
// rtl/kmac_ss_digest_streamer.sv - snapshots the Keccak state and streams the digest as 32-bit words (option: KMAC_SS_DIGEST_ZEROIZE_EN)
module kmac_ss_digest_streamer
    import kmac_ss_pkg::*;
#(
    parameter bit EnMasking = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  state_valid_i,
    input  logic [StateW-1:0]     state_i [EnMasking ? 2 : 1],
    input  logic [DigestLenW-1:0] len_words_i,
    input  logic                  endian_swap_i,
    output logic [31:0]           data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  data_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int Share = EnMasking ? 2 : 1;

    digest_st_e            r_fsm;
    logic [DigestLenW-1:0] r_idx;
    logic [DigestLenW-1:0] r_len;
    logic                  r_swap;
    logic [StateW-1:0]     r_snap;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [StateW-1:0]     w_unmasked;
    logic [31:0]           w_word;
    logic                  w_len_ok;

    // Recombine the XOR shares into the plain state.
    always_comb begin
        w_unmasked = '0;
        for (int s = 0; s < Share; s++) begin
            w_unmasked = w_unmasked ^ state_i[s];
        end
    end

    assign w_len_ok = (len_words_i != '0) && (len_words_i <= DigestLenW'(DigestMaxWords));

    caliptra_prim_slicer #(
        .InW    (StateW),
        .OutW   (32),
        .IndexW (DigestLenW)
    ) u_slicer (
        .sel_i  (r_idx),
        .data_i (r_snap),
        .data_o (w_word)
    );

    // Capture / stream / done sequencing with registered handshake and status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fsm   <= StIdle;
            r_idx   <= '0;
            r_len   <= '0;
            r_swap  <= 1'b0;
            r_snap  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_fsm)
                StIdle: begin
                    if (state_valid_i) begin
                        if (w_len_ok) begin
                            r_snap  <= w_unmasked;
                            r_len   <= len_words_i;
                            r_swap  <= endian_swap_i;
                            r_idx   <= '0;
                            r_valid <= 1'b1;
                            r_last  <= (len_words_i == DigestLenW'(1));
                            r_busy  <= 1'b1;
                            r_fsm   <= StStream;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StStream: begin
                    if (r_valid && data_ready_i) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_fsm   <= StDone;
                        end else begin
                            r_idx  <= r_idx + DigestLenW'(1);
                            // Next word is the last one when idx+1 == len-1.
                            r_last <= ((r_idx + DigestLenW'(2)) == r_len);
                        end
                    end
                end
                StDone: begin
`ifdef KMAC_SS_DIGEST_ZEROIZE_EN
                    r_snap <= '0;
`endif
                    r_busy <= 1'b0;
                    r_fsm  <= StIdle;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_fsm   <= StIdle;
                end
            endcase
        end
    end

`ifdef KMAC_SS_DIGEST_ZEROIZE_EN
    assign data_o = (r_fsm == StIdle) ? 32'h0 : conv_endian32(w_word, r_swap);
`else
    assign data_o = conv_endian32(w_word, r_swap);
`endif

    assign data_valid_o = r_valid;
    assign data_last_o  = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: doc/kmac_ss_digest_streamer.md
KMAC_SS_DIGEST_STREAMER -- requirements
Module: kmac_ss_digest_streamer

Interface
REQ-001 SHALL have parameter EnMasking, default 1'b0, meaning state arrives as two XOR shares when set.
REQ-002 SHALL have localparam Share, value (EnMasking ? 2 : 1), meaning number of state shares.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-004 SHALL have port rst_ni, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port state_valid_i, input, 1, meaning a one-cycle pulse: the Keccak state is final and may be captured.
REQ-006 SHALL have port state_i, input, StateW x [Share], meaning the Keccak state shares.
REQ-007 SHALL have port len_words_i, input, 6, meaning the digest length in 32-bit words, sampled with state_valid_i.
REQ-008 SHALL have port endian_swap_i, input, 1, meaning per-word byte swap, sampled with state_valid_i.
REQ-009 SHALL have port data_o, output, 32, meaning the streamed digest word.
REQ-010 SHALL have port data_valid_o, output, 1, meaning data_o is valid.
REQ-011 SHALL have port data_ready_i, input, 1, meaning the consumer accepts data_o.
REQ-012 SHALL have port data_last_o, output, 1, meaning the final word of the digest.
REQ-013 SHALL have port busy_o, output, 1, meaning the FSM is not in Idle.
REQ-014 SHALL have port done_o, output, 1, meaning a one-cycle pulse after the final word is accepted.
REQ-015 SHALL have port err_o, output, 1, meaning a one-cycle pulse on a capture request with an illegal length.

Function
REQ-016 SHALL implement the FSM states Idle, Stream and Done.
REQ-017 In Idle, when state_valid_i=1 and 1<=len_words_i<=50, the block SHALL:
- capture the unmasked state (XOR of all shares);
- latch len_words_i and endian_swap_i;
- clear the word index;
- go to Stream on the next cycle.
REQ-018 In Idle, when state_valid_i=1 and len_words_i is 0 or greater than 50, the block SHALL pulse err_o on the next cycle, stay in Idle, and leave the snapshot unchanged.
REQ-019 In Stream, data_valid_o SHALL be 1 and data_o SHALL equal conv_endian32(word[index], latched swap); word 0 is state bits [31:0].
REQ-020 The first data_valid_o SHALL assert exactly one cycle after the accepted state_valid_i.
REQ-021 data_o and data_last_o SHALL hold stable while data_valid_o=1 and data_ready_i=0.
REQ-022 The word index SHALL increment only on data_valid_o and data_ready_i both high; index width is 6 bits and it never wraps.
REQ-023 data_last_o SHALL be 1 exactly when index == len-1 in Stream.
REQ-024 When the last word is accepted, the FSM SHALL go to Done; Done SHALL last one cycle, during which done_o=1 and data_valid_o=0, then return to Idle.
REQ-025 state_valid_i SHALL be ignored in Stream and Done, with no err_o and no recapture.
REQ-026 busy_o SHALL be 1 in Stream and Done.
REQ-027 When len=1, the first word SHALL carry data_last_o=1.

Reset
REQ-028 While rst_ni=0 at a clk_i edge, the block SHALL:
- set the FSM to Idle;
- set the index to 0;
- clear the snapshot and latched len/swap to 0;
- drive data_valid_o, data_last_o, busy_o, done_o and err_o to 0;
- drive data_o to 0.
REQ-029 Reset asserted mid-stream SHALL abort the stream with no done_o pulse; the block SHALL be in Idle at the first edge with rst_ni=1.

Configuration
REQ-030 When KMAC_SS_DIGEST_ZEROIZE_EN is defined, the snapshot SHALL be cleared to 0 in the Done cycle and data_o SHALL read 0 whenever the FSM is in Idle.
REQ-031 When KMAC_SS_DIGEST_ZEROIZE_EN is undefined, the snapshot SHALL be retained until the next capture, and data_o in Idle is don't-care.

Structure
REQ-032 kmac_ss_pkg SHALL hold:
- DigestMaxWords = 50 (StateW/32);
- DigestLenW = 6;
- the FSM state enum;
- conv_endian32.
REQ-033 Word selection SHALL use one caliptra_prim_slicer instance (InW=StateW, OutW=32, IndexW=DigestLenW) on the snapshot.

Verification
REQ-034 Capture state word0=0x11223344, word1=0xAABBCCDD, len=2, swap=0, ready held 1 -> data_o 0x11223344 then 0xAABBCCDD, data_last_o on the second word, done_o one cycle later.
REQ-035 Same state with swap=1 and len=1 -> single word 0x44332211 with data_last_o=1.
REQ-036 EnMasking=1, share0 word0=0xFFFF0000, share1 word0=0x0F0F0F0F, len=1 -> data_o=0xF0F00F0F.
REQ-037 len=0, then len=51 -> err_o pulses twice, busy_o stays 0, no data_valid_o.
REQ-038 len=50, with data_ready_i low for 3 cycles at word 7 and a state_valid_i pulse mid-stream -> data_o stable during the stall, 50 words total, the pulse is ignored.
REQ-039 rst_ni=0 at word 3 of len=8 -> all outputs 0 and no done_o; with KMAC_SS_DIGEST_ZEROIZE_EN defined, data_o reads 0 in Idle after a completed stream.
